// File: rtl/dport_arb_pkg.sv
// Shared types and constants for the data-port arbiter: request payload,
// op-vector layout and requester ids.
package dport_arb_pkg;

  localparam int unsigned DPORT_ADDR_W = 32;
  localparam int unsigned DPORT_DATA_W = 32;
  localparam int unsigned DPORT_TAG_W  = 11;
  localparam int unsigned DPORT_BE_W   = 4;

  localparam logic DPORT_ARB_ID_LSU = 1'b0;
  localparam logic DPORT_ARB_ID_DBG = 1'b1;

  // Bit positions inside the op vector; any set bit makes a live request.
  localparam int unsigned DPORT_OP_W     = 5;
  localparam int unsigned DPORT_OP_RD    = 0;
  localparam int unsigned DPORT_OP_WR    = 1;
  localparam int unsigned DPORT_OP_FLUSH = 2;
  localparam int unsigned DPORT_OP_INV   = 3;
  localparam int unsigned DPORT_OP_WB    = 4;

  typedef logic [DPORT_OP_W-1:0] dport_op_t;

  typedef struct packed {
    logic [DPORT_ADDR_W-1:0] addr;
    logic [DPORT_DATA_W-1:0] data_wr;
    logic                    rd;
    logic [DPORT_BE_W-1:0]   wr;
    logic                    cacheable;
    logic [DPORT_TAG_W-1:0]  req_tag;
    logic                    invalidate;
    logic                    writeback;
    logic                    flush;
  } dport_req_t;

  typedef enum logic {
    LOCK_OPEN = 1'b0,
    LOCK_HELD = 1'b1
  } dport_lock_e;

  function automatic dport_op_t dport_op_vec(input dport_req_t r);
    dport_op_t op;
    op                 = '0;
    op[DPORT_OP_RD]    = r.rd;
    op[DPORT_OP_WR]    = |r.wr;
    op[DPORT_OP_FLUSH] = r.flush;
    op[DPORT_OP_INV]   = r.invalidate;
    op[DPORT_OP_WB]    = r.writeback;
    return op;
  endfunction

endpackage

// File: rtl/dport_arb_fifo.sv
// Owner FIFO: one bit per outstanding downstream request naming the requester
// that owns the next in-order response.
module dport_arb_fifo #(
  parameter int unsigned PEND_DEPTH   = 4,
  parameter int unsigned PEND_DEPTH_W = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  data_i,
  input  logic                  pop_i,
  output logic                  data_o,
  output logic [PEND_DEPTH_W:0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned CNT_W = PEND_DEPTH_W + 1;

  logic [PEND_DEPTH-1:0]   mem_q;
  logic [PEND_DEPTH_W-1:0] wr_ptr_q;
  logic [PEND_DEPTH_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic                    do_push;
  logic                    do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(PEND_DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop on the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PEND_DEPTH_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PEND_DEPTH_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dport_arb.sv
// Two-requester data-port arbiter (port 0 LSU, port 1 debug/DMA) with grant
// lock until accept and in-order response routing. DPORT_ARB_RR_EN selects
// round-robin tie-break; otherwise the LSU wins ties.
module dport_arb
  import dport_arb_pkg::*;
#(
  parameter int unsigned PEND_DEPTH   = 4,
  parameter int unsigned PEND_DEPTH_W = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic [DPORT_ADDR_W-1:0] mem0_addr_i,
  input  logic [DPORT_DATA_W-1:0] mem0_data_wr_i,
  input  logic                    mem0_rd_i,
  input  logic [DPORT_BE_W-1:0]   mem0_wr_i,
  input  logic                    mem0_cacheable_i,
  input  logic [DPORT_TAG_W-1:0]  mem0_req_tag_i,
  input  logic                    mem0_invalidate_i,
  input  logic                    mem0_writeback_i,
  input  logic                    mem0_flush_i,
  output logic                    mem0_accept_o,
  output logic                    mem0_ack_o,
  output logic                    mem0_error_o,
  output logic [DPORT_DATA_W-1:0] mem0_data_rd_o,
  output logic [DPORT_TAG_W-1:0]  mem0_resp_tag_o,

  input  logic [DPORT_ADDR_W-1:0] mem1_addr_i,
  input  logic [DPORT_DATA_W-1:0] mem1_data_wr_i,
  input  logic                    mem1_rd_i,
  input  logic [DPORT_BE_W-1:0]   mem1_wr_i,
  input  logic                    mem1_cacheable_i,
  input  logic [DPORT_TAG_W-1:0]  mem1_req_tag_i,
  input  logic                    mem1_invalidate_i,
  input  logic                    mem1_writeback_i,
  input  logic                    mem1_flush_i,
  output logic                    mem1_accept_o,
  output logic                    mem1_ack_o,
  output logic                    mem1_error_o,
  output logic [DPORT_DATA_W-1:0] mem1_data_rd_o,
  output logic [DPORT_TAG_W-1:0]  mem1_resp_tag_o,

  output logic [DPORT_ADDR_W-1:0] mem_addr_o,
  output logic [DPORT_DATA_W-1:0] mem_data_wr_o,
  output logic                    mem_rd_o,
  output logic [DPORT_BE_W-1:0]   mem_wr_o,
  output logic                    mem_cacheable_o,
  output logic [DPORT_TAG_W-1:0]  mem_req_tag_o,
  output logic                    mem_invalidate_o,
  output logic                    mem_writeback_o,
  output logic                    mem_flush_o,
  input  logic                    mem_accept_i,
  input  logic                    mem_ack_i,
  input  logic                    mem_error_i,
  input  logic [DPORT_DATA_W-1:0] mem_data_rd_i,
  input  logic [DPORT_TAG_W-1:0]  mem_resp_tag_i
);

  localparam int unsigned CNT_W = PEND_DEPTH_W + 1;

  dport_req_t       req0_c;
  dport_req_t       req1_c;
  dport_req_t       sel_c;
  logic [1:0]       req_c;

  dport_lock_e      state_q;
  dport_lock_e      state_d;
  logic             lock_id_q;
  logic             lock_id_d;
  logic             lock_q;

  logic             tie_id_c;
  logic             grant_c;
  logic             gnt_req_c;
  logic             issue_c;
  logic             accept_c;
  logic             ack_ok_c;

  logic             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] pend_cnt;

  assign req0_c = '{addr: mem0_addr_i, data_wr: mem0_data_wr_i, rd: mem0_rd_i,
                    wr: mem0_wr_i, cacheable: mem0_cacheable_i, req_tag: mem0_req_tag_i,
                    invalidate: mem0_invalidate_i, writeback: mem0_writeback_i,
                    flush: mem0_flush_i};
  assign req1_c = '{addr: mem1_addr_i, data_wr: mem1_data_wr_i, rd: mem1_rd_i,
                    wr: mem1_wr_i, cacheable: mem1_cacheable_i, req_tag: mem1_req_tag_i,
                    invalidate: mem1_invalidate_i, writeback: mem1_writeback_i,
                    flush: mem1_flush_i};

  assign req_c[0] = |dport_op_vec(req0_c);
  assign req_c[1] = |dport_op_vec(req1_c);

  // Tie-break: last-granted port yields under round-robin.
`ifdef DPORT_ARB_RR_EN
  logic rr_last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_last_q <= DPORT_ARB_ID_DBG;
    end else if (accept_c) begin
      rr_last_q <= grant_c;
    end
  end

  assign tie_id_c = ~rr_last_q;
`else
  assign tie_id_c = DPORT_ARB_ID_LSU;
`endif

  // Lock state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= LOCK_OPEN;
      lock_id_q <= DPORT_ARB_ID_LSU;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  assign lock_q = (state_q == LOCK_HELD);

  // Next-state: hold the grant on a presented but unaccepted request.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      LOCK_OPEN: begin
        if (gnt_req_c && !accept_c) begin
          state_d   = LOCK_HELD;
          lock_id_d = grant_c;
        end
      end
      LOCK_HELD: begin
        if (accept_c) begin
          state_d = LOCK_OPEN;
        end
      end
      default: state_d = LOCK_OPEN;
    endcase
  end

  // Outputs: grant select, full gating and downstream handshake.
  always_comb begin
    grant_c = DPORT_ARB_ID_LSU;
    if (lock_q) begin
      grant_c = lock_id_q;
    end else if (&req_c) begin
      grant_c = tie_id_c;
    end else if (req_c[1]) begin
      grant_c = DPORT_ARB_ID_DBG;
    end
    sel_c     = (grant_c == DPORT_ARB_ID_DBG) ? req1_c : req0_c;
    gnt_req_c = req_c[grant_c];
    issue_c   = gnt_req_c & ~(fifo_full & ~mem_ack_i) & ~rst_i;
    accept_c  = issue_c & mem_accept_i;
  end

  assign mem_addr_o       = sel_c.addr;
  assign mem_data_wr_o    = sel_c.data_wr;
  assign mem_cacheable_o  = sel_c.cacheable;
  assign mem_req_tag_o    = sel_c.req_tag;
  assign mem_rd_o         = issue_c & sel_c.rd;
  assign mem_wr_o         = issue_c ? sel_c.wr : '0;
  assign mem_invalidate_o = issue_c & sel_c.invalidate;
  assign mem_writeback_o  = issue_c & sel_c.writeback;
  assign mem_flush_o      = issue_c & sel_c.flush;

  assign mem0_accept_o = accept_c & (grant_c == DPORT_ARB_ID_LSU);
  assign mem1_accept_o = accept_c & (grant_c == DPORT_ARB_ID_DBG);

  dport_arb_fifo #(
    .PEND_DEPTH   (PEND_DEPTH),
    .PEND_DEPTH_W (PEND_DEPTH_W)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept_c),
    .data_i  (grant_c),
    .pop_i   (mem_ack_i),
    .data_o  (fifo_head),
    .count_o (pend_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Responses with no outstanding owner are dropped.
  assign ack_ok_c   = mem_ack_i & ~fifo_empty & ~rst_i;
  assign mem0_ack_o = ack_ok_c & (fifo_head == DPORT_ARB_ID_LSU);
  assign mem1_ack_o = ack_ok_c & (fifo_head == DPORT_ARB_ID_DBG);

  assign mem0_error_o    = mem_error_i;
  assign mem1_error_o    = mem_error_i;
  assign mem0_data_rd_o  = mem_data_rd_i;
  assign mem1_data_rd_o  = mem_data_rd_i;
  assign mem0_resp_tag_o = mem_resp_tag_i;
  assign mem1_resp_tag_o = mem_resp_tag_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (pend_cnt <= CNT_W'(PEND_DEPTH));
    end
  end

endmodule
